// File: rtl/serial_link_pkg.sv
// Shared definitions for the serial link: aligner state encoding,
// the default sync word used by the transmit framer, and counter widths.
package serial_link_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } align_state_e;

  localparam logic [7:0] SYNC_WORD_DEFAULT = 8'hBC;

  localparam int PERIOD_CNT_W = 8;
  localparam int GOOD_CNT_W   = 4;
  localparam int MISS_RUN_W   = 4;

endpackage

// File: rtl/serial_rx_sync_detect.sv
// Combinational matcher: tests all 8 bit offsets of the 16-bit window
// against the sync word and reports the lowest matching offset.
module serial_rx_sync_detect
  import serial_link_pkg::*;
(
  input  logic [15:0] window,
  input  logic [7:0]  sync_word,
  output logic        hit,
  output logic [2:0]  hit_offset
);

  // Scan from the top down so the lowest matching offset is written last.
  always_comb begin
    hit        = 1'b0;
    hit_offset = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (window[i +: 8] == sync_word) begin
        hit        = 1'b1;
        hit_offset = 3'(i);
      end
    end
  end

endmodule

// File: rtl/serial_rx_align.sv
// Receive word aligner: hunts for the periodic sync word, qualifies lock
// over several sync periods and delivers byte-aligned words while locked.
module serial_rx_align
  import serial_link_pkg::*;
#(
  parameter logic [7:0] SYNC_WORD    = SYNC_WORD_DEFAULT,
  parameter int         SYNC_PERIOD  = 16,
  parameter int         LOCK_COUNT   = 3,
  parameter int         UNLOCK_COUNT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        data_valid,
  output logic        sync_flag,
  output logic        locked,
  output logic [2:0]  offset,
  output logic [15:0] miss_count
);

  localparam logic [PERIOD_CNT_W-1:0] PERIOD_LAST = PERIOD_CNT_W'(SYNC_PERIOD);
  localparam logic [GOOD_CNT_W-1:0]   GOOD_LAST   = GOOD_CNT_W'(LOCK_COUNT);
  localparam logic [MISS_RUN_W-1:0]   MISS_LAST   = MISS_RUN_W'(UNLOCK_COUNT);

  align_state_e              state, state_next;
  logic [7:0]                data_prev;
  logic [15:0]               window;
  logic [7:0]                aligned;
  logic                      det_hit;
  logic [2:0]                det_offset;
  logic [PERIOD_CNT_W-1:0]   period_cnt, period_cnt_next;
  logic [GOOD_CNT_W-1:0]     good_cnt, good_cnt_next;
  logic [MISS_RUN_W-1:0]     miss_run, miss_run_next;
  logic [2:0]                offset_next;
  logic [15:0]               miss_count_next;
  logic                      at_boundary;
  logic                      aligned_match;
  logic                      valid_next;
  logic                      sync_next;

  // data_prev holds the earlier bits, so the window reads oldest bit first.
  assign window        = {data_in, data_prev};
  assign aligned       = window[offset +: 8];
  assign at_boundary   = (state != HUNT) && (period_cnt == PERIOD_LAST);
  assign aligned_match = (aligned == SYNC_WORD);

  serial_rx_sync_detect u_sync_detect (
    .window     (window),
    .sync_word  (SYNC_WORD),
    .hit        (det_hit),
    .hit_offset (det_offset)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= HUNT;
      period_cnt <= '0;
      good_cnt   <= '0;
      miss_run   <= '0;
      offset     <= '0;
      miss_count <= '0;
      data_prev  <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      sync_flag  <= 1'b0;
      locked     <= 1'b0;
    end else begin
      state      <= state_next;
      period_cnt <= period_cnt_next;
      good_cnt   <= good_cnt_next;
      miss_run   <= miss_run_next;
      offset     <= offset_next;
      miss_count <= miss_count_next;
      data_prev  <= data_in;
      data_out   <= aligned;
      data_valid <= valid_next;
      sync_flag  <= sync_next;
      locked     <= valid_next;
    end
  end

  always_comb begin
    state_next      = state;
    period_cnt_next = period_cnt + 1'b1;
    good_cnt_next   = good_cnt;
    miss_run_next   = miss_run;
    offset_next     = offset;
    miss_count_next = miss_count;
    case (state)
      HUNT: begin
        period_cnt_next = period_cnt;
        if (det_hit) begin
          state_next      = VERIFY;
          offset_next     = det_offset;
          period_cnt_next = PERIOD_CNT_W'(1);
          good_cnt_next   = '0;
        end
      end
      VERIFY: begin
        if (at_boundary) begin
          if (aligned_match) begin
            period_cnt_next = PERIOD_CNT_W'(1);
            good_cnt_next   = good_cnt + 1'b1;
            if (good_cnt_next == GOOD_LAST) begin
              state_next    = LOCKED;
              miss_run_next = '0;
            end
          end else begin
            state_next = HUNT;
          end
        end
      end
      LOCKED: begin
        // A miss still wraps the period so the expected position is kept.
        if (at_boundary) begin
          period_cnt_next = PERIOD_CNT_W'(1);
          if (aligned_match) begin
            miss_run_next = '0;
          end else begin
            miss_run_next = miss_run + 1'b1;
            if (miss_count != 16'hFFFF) miss_count_next = miss_count + 16'd1;
            if (miss_run_next == MISS_LAST) state_next = HUNT;
          end
        end
      end
      default: state_next = HUNT;
    endcase
  end

  // data_valid has no ready: the consumer must take every word while it is high.
  always_comb begin
    valid_next = (state_next == LOCKED);
    sync_next  = valid_next && at_boundary && aligned_match;
  end

endmodule

// File: tb/tb_serial_rx_align.sv
// Directed bench for serial_rx_align: shifted bitstream with periodic sync,
// a per-cycle reference model and hand-computed literal expectations.
module tb_serial_rx_align;
  import serial_link_pkg::*;

  localparam int         P  = 16;
  localparam int         LK = 3;
  localparam int         UL = 4;
  localparam logic [7:0] SW = 8'hBC;
  localparam int         EW = 30;
  localparam int         N_WORDS = 530;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        sync_flag;
  logic        locked;
  logic [2:0]  offset;
  logic [15:0] miss_count;

  always #5 clk = ~clk;

  serial_rx_align dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .data_in    (data_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .sync_flag  (sync_flag),
    .locked     (locked),
    .offset     (offset),
    .miss_count (miss_count)
  );

  int errors = 0;
  int checks = 0;
  int word_idx = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s word=%0d got=%0h expected=%0h", name, word_idx, act, exp);
    end
  endtask

  // Scoreboard: {data_out, data_valid, sync_flag, locked, offset, miss_count}
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_word;

  // Reference model: tracks the absolute cycle at which the next sync is due.
  int         m_t = 0;
  int         m_mode = 0;  // 0 hunting, 1 verifying, 2 locked
  int         m_off = 0;
  int         m_due = 0;
  int         m_good = 0;
  int         m_run = 0;
  int         m_miss = 0;
  logic [7:0] m_prev = 8'h00;

  task automatic model_step(input logic rst, input logic [7:0] din);
    logic [15:0] win;
    logic [7:0]  al;
    logic        v;
    logic        s;
    bit          due;
    m_t++;
    if (!rst) begin
      m_mode = 0;
      m_off  = 0;
      m_miss = 0;
      m_prev = 8'h00;
      exp_q.push_back('0);
      return;
    end
    win = {din, m_prev};
    al  = 8'(win >> m_off);
    due = (m_mode != 0) && (m_t == m_due);
    v = 1'b0;
    s = 1'b0;
    if (m_mode == 0) begin
      for (int j = 0; j < 8; j++) begin
        if (8'(win >> j) == SW) begin
          m_off  = j;
          m_due  = m_t + P;
          m_good = 0;
          m_mode = 1;
          break;
        end
      end
    end else if (m_mode == 1) begin
      if (due) begin
        if (al == SW) begin
          m_good++;
          m_due += P;
          if (m_good == LK) begin
            m_mode = 2;
            m_run  = 0;
            v = 1'b1;
            s = 1'b1;
          end
        end else begin
          m_mode = 0;
        end
      end
    end else begin
      v = 1'b1;
      if (due) begin
        m_due += P;
        if (al == SW) begin
          m_run = 0;
          s = 1'b1;
        end else begin
          m_run++;
          if (m_miss < 65535) m_miss++;
          if (m_run == UL) begin
            m_mode = 0;
            v = 1'b0;
          end
        end
      end
    end
    m_prev = din;
    exp_q.push_back({al, v, s, v, 3'(m_off), 16'(m_miss)});
  endtask

  // Compare process: one expected entry per driven cycle.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_word = exp_q.pop_front();
      check("data_out",   32'(data_out),   32'(exp_word[29:22]));
      check("data_valid", 32'(data_valid), 32'(exp_word[21]));
      check("sync_flag",  32'(sync_flag),  32'(exp_word[20]));
      check("locked",     32'(locked),     32'(exp_word[19]));
      check("offset",     32'(offset),     32'(exp_word[18:16]));
      check("miss_count", 32'(miss_count), 32'(exp_word[15:0]));
    end
  end

  // Stream: 3 leading bits, shift grows to 6 at byte 320.
  bit bits_q[$];

  function automatic logic [7:0] byte_val(input int i);
    if (i == 5) return SW;
    if (i % 16 == 0) begin
      if (i == 112 || i == 128 || i == 144 || i == 176 ||
          i == 192 || i == 208 || i == 224) return 8'h00;
      return SW;
    end
    return 8'(i % 16);
  endfunction

  function automatic logic [7:0] word_at(input int w);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = bits_q[8 * w + k];
    return r;
  endfunction

  task automatic drive(input logic rst, input logic [7:0] d);
    @(negedge clk);
    reset_n = rst;
    data_in = d;
    model_step(rst, d);
    @(posedge clk);
    #2;
  endtask

  int first_lock = -1;

  initial begin
    logic [7:0] b;
    repeat (3) bits_q.push_back(1'b0);
    for (int i = 0; i < 540; i++) begin
      if (i == 320) repeat (3) bits_q.push_back(1'b0);
      b = byte_val(i);
      for (int k = 0; k < 8; k++) bits_q.push_back(b[k]);
    end

    for (int r = 0; r < 4; r++) begin
      drive(1'b0, 8'($urandom_range(0, 255)));
      check("rst_data_out", 32'(data_out), 32'h0);
      check("rst_valid", 32'(data_valid), 32'h0);
      check("rst_sync", 32'(sync_flag), 32'h0);
      check("rst_locked", 32'(locked), 32'h0);
      check("rst_offset", 32'(offset), 32'h0);
      check("rst_miss", 32'(miss_count), 32'h0);
    end

    for (int w = 0; w < N_WORDS; w++) begin
      word_idx = w;
      drive((w == 460) ? 1'b0 : 1'b1, word_at(w));
      if (locked && first_lock < 0) first_lock = w;
      case (w)
        0, 48, 512: check("lit_locked_low", 32'(locked), 32'h0);
        49: begin
          check("lit_lock_rise", 32'(locked), 32'h1);
          check("lit_offset3", 32'(offset), 32'h3);
          check("lit_lock_sync", 32'(sync_flag), 32'h1);
          check("lit_lock_word", 32'(data_out), 32'hBC);
        end
        51: begin
          check("lit_payload", 32'(data_out), 32'h02);
          check("lit_payload_valid", 32'(data_valid), 32'h1);
          check("lit_payload_sync", 32'(sync_flag), 32'h0);
        end
        65: check("lit_sync_pulse", 32'(sync_flag), 32'h1);
        161: begin
          check("lit_tolerate_locked", 32'(locked), 32'h1);
          check("lit_miss3", 32'(miss_count), 32'd3);
        end
        224, 368: check("lit_still_locked", 32'(locked), 32'h1);
        225: begin
          check("lit_drop_locked", 32'(locked), 32'h0);
          check("lit_drop_valid", 32'(data_valid), 32'h0);
          check("lit_miss7", 32'(miss_count), 32'd7);
        end
        289: begin
          check("lit_relock", 32'(locked), 32'h1);
          check("lit_relock_off", 32'(offset), 32'h3);
        end
        369: begin
          check("lit_realign_drop", 32'(locked), 32'h0);
          check("lit_miss11", 32'(miss_count), 32'd11);
        end
        433: begin
          check("lit_realign_lock", 32'(locked), 32'h1);
          check("lit_offset6", 32'(offset), 32'h6);
        end
        460: begin
          check("lit_rst_locked", 32'(locked), 32'h0);
          check("lit_rst_miss", 32'(miss_count), 32'h0);
        end
        513: begin
          check("lit_reacq_lock", 32'(locked), 32'h1);
          check("lit_reacq_off", 32'(offset), 32'h6);
          check("lit_reacq_miss", 32'(miss_count), 32'h0);
        end
        default: ;
      endcase
    end
    // Detection at word 1; locked first seen after word 49 (cycle 50).
    check("lit_first_lock_word", 32'(first_lock), 32'd49);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_rx_align.md
# serial_rx_align

Receive-side word aligner for the serial link. It takes unaligned 8-bit parallel words from the input deserializer and finds the byte boundary by searching for a periodic sync word inserted by the transmitter. It qualifies lock over several sync periods, then delivers aligned bytes to the link layer. Simulation builds pair it with the dummy serializer path; hardware builds feed it from the ISERDES in the same clock domain.

## Interface
- SYNC_WORD, 8'hBC: alignment pattern the transmitter sends every SYNC_PERIOD words.
- SYNC_PERIOD, 16: words per sync interval, sync word included. Legal range is 2..255.
- LOCK_COUNT, 3: consecutive on-time syncs after first detection required for lock. Legal range is 1..15.
- UNLOCK_COUNT, 4: consecutive missed syncs while locked that drop lock. Legal range is 1..15.
- clk  in  1  word clock, the deserializer divided clock.
- reset_n  in  1  synchronous, active-low reset.
- data_in  in  8  raw deserializer word. Bit 0 is the earliest received bit.
- data_out  out  8  aligned word.
- data_valid  out  1  data_out holds an aligned word. Asserted only while locked.
- sync_flag  out  1  data_out is an on-time sync word. Qualified by data_valid.
- locked  out  1  alignment is locked.
- offset  out  3  current bit offset in use.
- miss_count  out  16  saturating count of missed syncs while locked.

## Operation
**Alignment window**
- window = {data_in, data_prev}, 16 bits. data_prev is data_in registered one cycle earlier.
- aligned = window[offset +: 8].

**States (HUNT, VERIFY, LOCKED)**
- HUNT
  - Each cycle, test all 8 offsets of window for SYNC_WORD.
  - On any match, latch the lowest matching offset, set period_cnt = 1 and good_cnt = 0, and go to VERIFY.
  - With no match, stay in HUNT.
- VERIFY
  - period_cnt increments each cycle.
  - When period_cnt == SYNC_PERIOD:
    - If aligned == SYNC_WORD, increment good_cnt and reset period_cnt to 1. If good_cnt reaches LOCK_COUNT, go to LOCKED with miss_run = 0.
    - Otherwise, go to HUNT.
  - Non-sync positions are not checked.
- LOCKED
  - Same period check as VERIFY.
  - A match clears miss_run.
  - A mismatch increments miss_run and miss_count (saturating at 16'hFFFF). The period counter still wraps to 1, so the expected position is kept.
  - When miss_run reaches UNLOCK_COUNT, go to HUNT. offset holds its last value until the next detection.
- An early or late SYNC_WORD (period_cnt != SYNC_PERIOD) is treated as data and does not trigger realignment.

**Outputs**
- data_out is registered from aligned every cycle in all states.
- data_valid = 1 for every word in LOCKED.
- sync_flag = 1 when data_valid is high and the word sat at the period boundary and matched.
- The locking match word itself is presented with data_valid = 1 and sync_flag = 1.

## Timing
- **Reset values:** data_out = 0, data_valid = 0, sync_flag = 0, locked = 0, offset = 0, miss_count = 0, data_prev = 0, state = HUNT.
- **Reset mid-operation:** all counters and state clear on the same edge. miss_count also clears.
- **Latency:** a word completed in data_in at cycle n appears on data_out at cycle n+1, with its data_valid and sync_flag.
- **locked:** rises on the same edge data_valid first rises, and falls on the edge data_valid falls.
- **Lock time:** with first detection at cycle n, locked rises at cycle n + LOCK_COUNT·SYNC_PERIOD + 1.
- **Drop-out:** after the UNLOCK_COUNT-th miss at cycle m, locked and data_valid are 0 from m+1. HUNT may detect again at m+1.
- **No flow control:** there is no backpressure. The downstream consumer must accept one word per cycle while data_valid is high.

## Structure
- serial_link_pkg holds:
  - the state enum (HUNT, VERIFY, LOCKED);
  - the default SYNC_WORD constant, shared with the transmit framer;
  - the localparam widths for period_cnt (8), good_cnt (4) and miss_run (4).
- One sub-module, serial_rx_sync_detect: a combinational 8-offset matcher that takes window and SYNC_WORD and returns hit plus the lowest offset (3 bits).
- The FSM, counters and output registers live in serial_rx_align.

## Test plan
- **Reset:** hold reset_n = 0 for 4 cycles with random data_in. All outputs stay at their reset values; after release, locked = 0.
- **Alignment at offset 3:** send a bitstream of SYNC_WORD every 16 words plus an incrementing payload, shifted by 3 bits. Expect offset = 3 and locked high exactly 49 cycles after first detection. data_out then equals the unshifted payload, and sync_flag pulses every 16th valid word.
- **False sync:** inject one 8'hBC payload byte at a non-boundary position during VERIFY. The state stays in VERIFY and lock timing is unchanged.
- **Miss tolerance:** while locked, corrupt 3 consecutive syncs and then restore. locked stays 1 and miss_count = 3. Corrupt 4 consecutive syncs: locked falls 1 cycle after the 4th and miss_count = 7.
- **Realign:** while locked, change the shift from 3 to 6. Lock is lost after 4 periods, then reacquired with offset = 6.
- **Reset while locked:** assert reset_n = 0 for 1 cycle. On the next edge locked = 0 and miss_count = 0, then a normal reacquire follows.
